// File: rtl/memory_stage_pkg.sv
// Shared definitions for the pd4 memory-access stage: FSM states,
// funct3 access-size encodings and writeback select encodings.
package memstage_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } mem_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Writeback result select, shared with decode and writeback
    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;
    localparam logic [1:0] WB_OFF = 2'd3;

    // Loads accept B/H/W/BU/HU; stores have no unsigned forms
    function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
        logic ok;
        if (is_store) begin
            ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end else begin
            ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                 (f3 == F3_BU) || (f3 == F3_HU);
        end
        return ok;
    endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane steering: store byte enables and replicated store
// data, plus load lane extraction with sign or zero extension.
module mem_align
    import memstage_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic [1:0]        byte_off,
    input  logic [2:0]        funct3,
    input  logic              is_store,
    input  logic [DWIDTH-1:0] store_data,
    input  logic [DWIDTH-1:0] load_raw,
    output logic [3:0]        be,
    output logic [DWIDTH-1:0] wdata,
    output logic [DWIDTH-1:0] load_data
);

    logic [DWIDTH-1:0] lane;

    // Replicate store data across lanes so the enables alone pick the bytes,
    // and shift the addressed load lane down to bit 0 before extending
    always_comb begin
        lane      = load_raw >> {byte_off, 3'b000};
        be        = 4'b1111;
        wdata     = store_data;
        load_data = lane;
        if (is_store) begin
            case (funct3[1:0])
                2'b00: begin
                    be    = 4'b0001 << byte_off;
                    wdata = {4{store_data[7:0]}};
                end
                2'b01: begin
                    be    = 4'b0011 << byte_off;
                    wdata = {2{store_data[15:0]}};
                end
                default: begin
                    be    = 4'b1111;
                    wdata = store_data;
                end
            endcase
        end
        case (funct3)
            F3_B:    load_data = {{(DWIDTH-8){lane[7]}}, lane[7:0]};
            F3_H:    load_data = {{(DWIDTH-16){lane[15]}}, lane[15:0]};
            F3_BU:   load_data = {{(DWIDTH-8){1'b0}}, lane[7:0]};
            F3_HU:   load_data = {{(DWIDTH-16){1'b0}}, lane[15:0]};
            default: load_data = lane;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// pd4 memory-access stage: turns loads/stores into a req/gnt/rvalid
// transaction, stalls upstream until the access completes, and hands
// extended load data to writeback alongside the passed-through pc/ALU result.
module memory_stage
    import memstage_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              valid_i,
    input  logic [AWIDTH-1:0] pc_i,
    input  logic [DWIDTH-1:0] alu_res_i,
    input  logic [DWIDTH-1:0] rs2_data_i,
    input  logic              memren_i,
    input  logic              memwen_i,
    input  logic [2:0]        funct3_i,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [AWIDTH-1:0] dmem_addr_o,
    output logic [DWIDTH-1:0] dmem_wdata_o,
    output logic [3:0]        dmem_be_o,
    input  logic              dmem_gnt_i,
    input  logic              dmem_rvalid_i,
    input  logic [DWIDTH-1:0] dmem_rdata_i,
    output logic [AWIDTH-1:0] pc_o,
    output logic [DWIDTH-1:0] alu_res_o,
    output logic [DWIDTH-1:0] memory_data_o,
    output logic              done_o,
    output logic              stall_o,
    output logic              access_err_o
);

    mem_state_e        state_q, state_d;
    logic [AWIDTH-1:0] addr_q;
    logic [DWIDTH-1:0] wdata_q;
    logic [DWIDTH-1:0] rdata_q;
    logic [2:0]        f3_q;
    logic              we_q;

    logic              mem_op;
    logic              misaligned;
    logic              illegal;
    logic              latch_en;
    logic              capture_en;
    logic              done_c;
    logic              stall_c;
    logic              err_c;

    logic [3:0]        align_be;
    logic [DWIDTH-1:0] align_wdata;
    logic [DWIDTH-1:0] align_load;

    // Upstream holds its inputs during a stall, so these are plain wires
    assign pc_o      = pc_i;
    assign alu_res_o = alu_res_i;

    // Alignment works on the latched fields so REQ outputs stay stable
    mem_align #(.DWIDTH(DWIDTH)) u_align (
        .byte_off   (addr_q[1:0]),
        .funct3     (f3_q),
        .is_store   (we_q),
        .store_data (wdata_q),
        .load_raw   (dmem_rdata_i),
        .be         (align_be),
        .wdata      (align_wdata),
        .load_data  (align_load)
    );

    // Decode legality of the incoming op; a set store enable wins over load
    always_comb begin
        mem_op     = memren_i | memwen_i;
        misaligned = ((funct3_i[1:0] == 2'b01) && alu_res_i[0]) ||
                     ((funct3_i[1:0] == 2'b10) && (alu_res_i[1:0] != 2'b00));
        illegal    = !f3_legal(funct3_i, memwen_i) || misaligned;
    end

    // Next-state and output logic; handshake outputs are forced low in reset
    always_comb begin
        state_d       = state_q;
        latch_en      = 1'b0;
        capture_en    = 1'b0;
        done_c        = 1'b0;
        stall_c       = 1'b0;
        err_c         = 1'b0;
        dmem_req_o    = 1'b0;
        dmem_we_o     = 1'b0;
        dmem_addr_o   = '0;
        dmem_wdata_o  = '0;
        dmem_be_o     = 4'b0000;
        memory_data_o = '0;
        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    if (!mem_op) begin
                        done_c = 1'b1;
                    end else if (illegal) begin
                        err_c  = 1'b1;
                        done_c = 1'b1;
                    end else begin
                        stall_c  = 1'b1;
                        latch_en = 1'b1;
                        state_d  = REQ;
                    end
                end
            end
            REQ: begin
                stall_c      = 1'b1;
                dmem_req_o   = 1'b1;
                dmem_we_o    = we_q;
                dmem_addr_o  = {addr_q[AWIDTH-1:2], 2'b00};
                dmem_wdata_o = we_q ? align_wdata : '0;
                dmem_be_o    = align_be;
                if (dmem_gnt_i) begin
                    if (we_q) begin
                        state_d = DONE;
                    end else if (dmem_rvalid_i) begin
                        capture_en = 1'b1;
                        state_d    = DONE;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                stall_c = 1'b1;
                if (dmem_rvalid_i) begin
                    capture_en = 1'b1;
                    state_d    = DONE;
                end
            end
            DONE: begin
                done_c        = 1'b1;
                memory_data_o = rdata_q;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
        done_o       = done_c & reset_n;
        stall_o      = stall_c & reset_n;
        access_err_o = err_c & reset_n;
    end

    // State register and capture registers; reset abandons any access
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            f3_q    <= 3'b000;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (latch_en) begin
                addr_q  <= alu_res_i;
                wdata_q <= rs2_data_i;
                f3_q    <= funct3_i;
                we_q    <= memwen_i;
                rdata_q <= '0;
            end
            if (capture_en) begin
                rdata_q <= align_load;
            end
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Directed, table-driven bench for memory_stage with a hand-driven
// request/grant/response memory side.
module tb_memory_stage;
    import memstage_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        valid_i;
    logic [31:0] pc_i;
    logic [31:0] alu_res_i;
    logic [31:0] rs2_data_i;
    logic        memren_i;
    logic        memwen_i;
    logic [2:0]  funct3_i;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    logic        dmem_gnt_i;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic [31:0] pc_o;
    logic [31:0] alu_res_o;
    logic [31:0] memory_data_o;
    logic        done_o;
    logic        stall_o;
    logic        access_err_o;

    int total;
    int bad;

    memory_stage #(.DWIDTH(32), .AWIDTH(32)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .valid_i       (valid_i),
        .pc_i          (pc_i),
        .alu_res_i     (alu_res_i),
        .rs2_data_i    (rs2_data_i),
        .memren_i      (memren_i),
        .memwen_i      (memwen_i),
        .funct3_i      (funct3_i),
        .dmem_req_o    (dmem_req_o),
        .dmem_we_o     (dmem_we_o),
        .dmem_addr_o   (dmem_addr_o),
        .dmem_wdata_o  (dmem_wdata_o),
        .dmem_be_o     (dmem_be_o),
        .dmem_gnt_i    (dmem_gnt_i),
        .dmem_rvalid_i (dmem_rvalid_i),
        .dmem_rdata_i  (dmem_rdata_i),
        .pc_o          (pc_o),
        .alu_res_o     (alu_res_o),
        .memory_data_o (memory_data_o),
        .done_o        (done_o),
        .stall_o       (stall_o),
        .access_err_o  (access_err_o)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic        valid;
        logic        ren;
        logic        wen;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic        e_done;
        logic        e_err;
    } idle_vec_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [31:0] rs2;
        logic [3:0]  gnt_delay;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
    } store_vec_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [31:0] rdata;
        logic [3:0]  gnt_delay;
        logic [3:0]  rv_delay;
        logic [31:0] e_data;
    } load_vec_t;

    idle_vec_t  idle_tab  [10];
    store_vec_t store_tab [5];
    load_vec_t  load_tab  [7];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic ren, input logic wen,
                                 input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] rs2);
        valid_i    = v;
        memren_i   = ren;
        memwen_i   = wen;
        funct3_i   = f3;
        alu_res_i  = addr;
        rs2_data_i = rs2;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Entered just after a rising edge with the FSM in IDLE; leaves in IDLE
    task automatic runStore(input string name, input store_vec_t sv);
        applyStimulus(1'b1, 1'b0, 1'b1, sv.f3, sv.addr, sv.rs2);
        @(negedge clk);
        checkOutput({name, " accept stall"}, 32'(stall_o), 32'd1);
        checkOutput({name, " accept req"}, 32'(dmem_req_o), 32'd0);
        nextCycle();
        for (int i = 0; i <= int'(sv.gnt_delay); i++) begin
            dmem_gnt_i = (i == int'(sv.gnt_delay));
            @(negedge clk);
            checkOutput({name, " req"}, 32'(dmem_req_o), 32'd1);
            checkOutput({name, " we"}, 32'(dmem_we_o), 32'd1);
            checkOutput({name, " addr"}, dmem_addr_o, sv.addr & 32'hFFFF_FFFC);
            checkOutput({name, " be"}, 32'(dmem_be_o), 32'(sv.e_be));
            checkOutput({name, " wdata"}, dmem_wdata_o, sv.e_wdata);
            checkOutput({name, " req done"}, 32'(done_o), 32'd0);
            nextCycle();
        end
        dmem_gnt_i = 1'b0;
        @(negedge clk);
        checkOutput({name, " done"}, 32'(done_o), 32'd1);
        checkOutput({name, " done stall"}, 32'(stall_o), 32'd0);
        checkOutput({name, " done data"}, memory_data_o, 32'd0);
        checkOutput({name, " done req"}, 32'(dmem_req_o), 32'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    endtask

    // rv_delay 0 means rvalid arrives together with the grant
    task automatic runLoad(input string name, input load_vec_t lv);
        applyStimulus(1'b1, 1'b1, 1'b0, lv.f3, lv.addr, 32'h5A5A_5A5A);
        @(negedge clk);
        checkOutput({name, " accept stall"}, 32'(stall_o), 32'd1);
        nextCycle();
        for (int i = 0; i <= int'(lv.gnt_delay); i++) begin
            dmem_gnt_i    = (i == int'(lv.gnt_delay));
            dmem_rvalid_i = (i == int'(lv.gnt_delay)) && (lv.rv_delay == 4'd0);
            dmem_rdata_i  = dmem_rvalid_i ? lv.rdata : 32'hDEAD_0000;
            @(negedge clk);
            checkOutput({name, " req"}, 32'(dmem_req_o), 32'd1);
            checkOutput({name, " we"}, 32'(dmem_we_o), 32'd0);
            checkOutput({name, " be"}, 32'(dmem_be_o), 32'hF);
            checkOutput({name, " addr"}, dmem_addr_o, lv.addr & 32'hFFFF_FFFC);
            nextCycle();
        end
        dmem_gnt_i = 1'b0;
        for (int j = 1; j <= int'(lv.rv_delay); j++) begin
            dmem_rvalid_i = (j == int'(lv.rv_delay));
            dmem_rdata_i  = dmem_rvalid_i ? lv.rdata : 32'hDEAD_0000;
            @(negedge clk);
            checkOutput({name, " wait stall"}, 32'(stall_o), 32'd1);
            checkOutput({name, " wait req"}, 32'(dmem_req_o), 32'd0);
            checkOutput({name, " wait done"}, 32'(done_o), 32'd0);
            nextCycle();
        end
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = 32'hDEAD_0000;
        @(negedge clk);
        checkOutput({name, " done"}, 32'(done_o), 32'd1);
        checkOutput({name, " done stall"}, 32'(stall_o), 32'd0);
        checkOutput({name, " data"}, memory_data_o, lv.e_data);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    endtask

    // Main sequence
    initial begin
        load_vec_t  lw_rst;
        store_vec_t sw_b2b;
        load_vec_t  lhu_b2b;

        total = 0;
        bad   = 0;

        idle_tab[0] = '{1'b1, 1'b0, 1'b0, 3'b000, 32'h0000_1234, 1'b1, 1'b0};
        idle_tab[1] = '{1'b0, 1'b1, 1'b0, F3_W,   32'h0000_3000, 1'b0, 1'b0};
        idle_tab[2] = '{1'b1, 1'b1, 1'b0, F3_H,   32'h0000_3001, 1'b1, 1'b1};
        idle_tab[3] = '{1'b1, 1'b1, 1'b0, F3_W,   32'h0000_3002, 1'b1, 1'b1};
        idle_tab[4] = '{1'b1, 1'b1, 1'b0, 3'b011, 32'h0000_3000, 1'b1, 1'b1};
        idle_tab[5] = '{1'b1, 1'b0, 1'b1, F3_BU,  32'h0000_3000, 1'b1, 1'b1};
        idle_tab[6] = '{1'b1, 1'b0, 1'b1, F3_H,   32'h0000_1001, 1'b1, 1'b1};
        idle_tab[7] = '{1'b1, 1'b0, 1'b1, F3_W,   32'h0000_1003, 1'b1, 1'b1};
        idle_tab[8] = '{1'b1, 1'b1, 1'b1, F3_HU,  32'h0000_3000, 1'b1, 1'b1};
        idle_tab[9] = '{1'b1, 1'b1, 1'b0, 3'b110, 32'h0000_3000, 1'b1, 1'b1};

        store_tab[0] = '{32'h0000_1003, F3_B, 32'hAABB_CCDD, 4'd2, 4'b1000, 32'hDDDD_DDDD};
        store_tab[1] = '{32'h0000_1000, F3_B, 32'h0000_00A5, 4'd0, 4'b0001, 32'hA5A5_A5A5};
        store_tab[2] = '{32'h0000_1002, F3_H, 32'h1234_5678, 4'd0, 4'b1100, 32'h5678_5678};
        store_tab[3] = '{32'h0000_1000, F3_H, 32'h1234_9ABC, 4'd1, 4'b0011, 32'h9ABC_9ABC};
        store_tab[4] = '{32'h0000_1004, F3_W, 32'hDEAD_BEEF, 4'd1, 4'b1111, 32'hDEAD_BEEF};

        load_tab[0] = '{32'h0000_2001, F3_B,  32'h0000_8000, 4'd0, 4'd1, 32'hFFFF_FF80};
        load_tab[1] = '{32'h0000_2001, F3_BU, 32'h0000_8000, 4'd0, 4'd1, 32'h0000_0080};
        load_tab[2] = '{32'h0000_3000, F3_W,  32'hCAFE_BABE, 4'd0, 4'd0, 32'hCAFE_BABE};
        load_tab[3] = '{32'h0000_2002, F3_H,  32'h8001_0000, 4'd1, 4'd2, 32'hFFFF_8001};
        load_tab[4] = '{32'h0000_2002, F3_HU, 32'h8001_0000, 4'd0, 4'd1, 32'h0000_8001};
        load_tab[5] = '{32'h0000_2003, F3_B,  32'h7F00_0000, 4'd0, 4'd0, 32'h0000_007F};
        load_tab[6] = '{32'h0000_2000, F3_H,  32'h0000_7FFF, 4'd2, 4'd1, 32'h0000_7FFF};

        reset_n       = 1'b0;
        pc_i          = 32'h0000_0400;
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = 32'd0;
        applyStimulus(1'b1, 1'b0, 1'b0, 3'b000, 32'h0000_0042, 32'd0);

        // Reset state: handshake outputs held low even with a valid op present
        @(negedge clk);
        checkOutput("reset done", 32'(done_o), 32'd0);
        checkOutput("reset stall", 32'(stall_o), 32'd0);
        checkOutput("reset err", 32'(access_err_o), 32'd0);
        checkOutput("reset req", 32'(dmem_req_o), 32'd0);
        checkOutput("reset data", memory_data_o, 32'd0);
        nextCycle();
        reset_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        nextCycle();

        // IDLE-cycle decode: pass-through and access errors
        for (int k = 0; k < 10; k++) begin
            pc_i = 32'h0000_0800 + 32'(k * 4);
            applyStimulus(idle_tab[k].valid, idle_tab[k].ren, idle_tab[k].wen,
                          idle_tab[k].f3, idle_tab[k].addr, 32'h1111_2222);
            @(negedge clk);
            checkOutput($sformatf("idle%0d done", k), 32'(done_o), 32'(idle_tab[k].e_done));
            checkOutput($sformatf("idle%0d err", k), 32'(access_err_o), 32'(idle_tab[k].e_err));
            checkOutput($sformatf("idle%0d stall", k), 32'(stall_o), 32'd0);
            checkOutput($sformatf("idle%0d req", k), 32'(dmem_req_o), 32'd0);
            checkOutput($sformatf("idle%0d data", k), memory_data_o, 32'd0);
            checkOutput($sformatf("idle%0d alu", k), alu_res_o, idle_tab[k].addr);
            checkOutput($sformatf("idle%0d pc", k), pc_o, 32'h0000_0800 + 32'(k * 4));
            nextCycle();
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        nextCycle();

        for (int k = 0; k < 5; k++) begin
            runStore($sformatf("store%0d", k), store_tab[k]);
        end
        for (int k = 0; k < 7; k++) begin
            runLoad($sformatf("load%0d", k), load_tab[k]);
        end

        // Reset while waiting for read data, then a stray rvalid afterwards
        applyStimulus(1'b1, 1'b1, 1'b0, F3_W, 32'h0000_5000, 32'd0);
        nextCycle();
        dmem_gnt_i = 1'b1;
        nextCycle();
        dmem_gnt_i = 1'b0;
        @(negedge clk);
        checkOutput("rst-wait stall", 32'(stall_o), 32'd1);
        #2;
        reset_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        #1;
        checkOutput("rst-wait in-reset stall", 32'(stall_o), 32'd0);
        checkOutput("rst-wait in-reset done", 32'(done_o), 32'd0);
        nextCycle();
        reset_n       = 1'b1;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'h1234_5678;
        @(negedge clk);
        checkOutput("rst-rv done", 32'(done_o), 32'd0);
        checkOutput("rst-rv stall", 32'(stall_o), 32'd0);
        checkOutput("rst-rv data", memory_data_o, 32'd0);
        nextCycle();
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = 32'd0;
        @(negedge clk);
        checkOutput("rst-after done", 32'(done_o), 32'd0);
        checkOutput("rst-after data", memory_data_o, 32'd0);
        nextCycle();
        lw_rst = '{32'h0000_5004, F3_W, 32'h0BAD_F00D, 4'd0, 4'd1, 32'h0BAD_F00D};
        runLoad("post-reset lw", lw_rst);

        // Back-to-back: the load is presented in the IDLE cycle after DONE
        sw_b2b  = '{32'h0000_4000, F3_W, 32'h0102_0304, 4'd0, 4'b1111, 32'h0102_0304};
        lhu_b2b = '{32'h0000_4002, F3_HU, 32'hBEEF_0000, 4'd0, 4'd1, 32'h0000_BEEF};
        runStore("b2b sw", sw_b2b);
        runLoad("b2b lhu", lhu_b2b);

        nextCycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
